// File: rtl/bcd_stopwatch_if.sv
// bcd_stopwatch_if: button inputs and display-side outputs of the stopwatch.
// The slave modport is the stopwatch core; master is whatever drives the keys
// and consumes the digits. Optional lap key present when STOPWATCH_LAP_EN is defined.
`timescale 1ns/1ps

interface bcd_stopwatch_if;
  logic        key_start_n;
  logic        key_clear_n;
`ifdef STOPWATCH_LAP_EN
  logic        key_lap_n;
`endif
  logic [23:0] digits;
  logic        running;
  logic        overflow;

`ifdef STOPWATCH_LAP_EN
  modport master (output key_start_n, key_clear_n, key_lap_n,
                  input  digits, running, overflow);
  modport slave  (input  key_start_n, key_clear_n, key_lap_n,
                  output digits, running, overflow);
`else
  modport master (output key_start_n, key_clear_n,
                  input  digits, running, overflow);
  modport slave  (input  key_start_n, key_clear_n,
                  output digits, running, overflow);
`endif
endinterface

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: MM:SS.cc stopwatch core feeding the seven-segment decoders.
// Debounced start/clear keys, IDLE/RUN/PAUSE control, centisecond divider and a
// six-digit BCD cascade wrapping at 59:59.99 with a one-cycle overflow pulse.
// Optional feature: define STOPWATCH_LAP_EN to add a lap key and lap-hold display.
`timescale 1ns/1ps

module bcd_stopwatch #(
  parameter int CLK_FREQ     = 50000000,
  parameter int TICK_HZ      = 100,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_stopwatch_if.slave  sw
);

  localparam int DIV_TC = CLK_FREQ / TICK_HZ - 1;
  localparam int DIV_W  = (DIV_TC > 0) ? $clog2(DIV_TC + 1) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam int KEY_START = 0;
  localparam int KEY_CLEAR = 1;
`ifdef STOPWATCH_LAP_EN
  localparam int KEY_LAP   = 2;
  localparam int NUM_KEYS  = 3;
`else
  localparam int NUM_KEYS  = 2;
`endif

  // Per-digit maxima, index 0 = centisecond units.
  localparam logic [3:0] DIG_MAX [6] = '{4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd5};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

  // ---------------------------------------------------------------------------
  // Key path: 2-FF synchroniser, stability counter, press on debounced 1->0.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] deb_q, deb_d;
  logic [DEB_W-1:0]    deb_cnt_q [NUM_KEYS];
  logic [DEB_W-1:0]    deb_cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] press;

`ifdef STOPWATCH_LAP_EN
  assign key_n = {sw.key_lap_n, sw.key_clear_n, sw.key_start_n};
`else
  assign key_n = {sw.key_clear_n, sw.key_start_n};
`endif

  // Stability count: runs while the synchronised level differs from the
  // debounced one, restarts whenever it falls back, commits after DEBOUNCE_CYC.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (which would infer a latch).
    deb_d = deb_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      deb_cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (deb_cnt_q[k] == DEB_W'(DEBOUNCE_CYC - 1)) begin
          deb_d[k] = sync2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // One-cycle press pulse, aligned with the edge that commits the low level.
  assign press = deb_q & ~deb_d;

  // Synchroniser and debounce registers; released (1) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      // NOTE: the counter array is a handful of flops, not RAM, so resetting it is cheap and keeps the first debounce window exact.
      for (int k = 0; k < NUM_KEYS; k++) deb_cnt_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int k = 0; k < NUM_KEYS; k++) deb_cnt_q[k] <= deb_cnt_d[k];
    end
  end

  logic start_evt, clear_evt;
  assign start_evt = press[KEY_START];
  assign clear_evt = press[KEY_CLEAR];

  // ---------------------------------------------------------------------------
  // Control FSM.
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   running_q;

  // Next state: clear wins over start; start toggles RUN/PAUSE or leaves IDLE.
  always_comb begin
    state_d = state_q;
    if (clear_evt) begin
      state_d = ST_IDLE;
    end else if (start_evt) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register with running decoded on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Centisecond divider: counts only in RUN, holds phase in PAUSE.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (state_q == ST_RUN) && (div_q == DIV_W'(DIV_TC));

  // Divider count; zeroed in IDLE so a fresh start sees a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (clear_evt || state_q == ST_IDLE) begin
      div_q <= '0;
    end else if (state_q == ST_RUN) begin
      div_q <= tick ? '0 : div_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // BCD cascade.
  // ---------------------------------------------------------------------------
  logic [23:0] count_q;
  logic [23:0] count_inc;
  logic        carry;
  logic        overflow_q;

  // Ripple-carry increment; a digit at (or somehow above) its max rolls to 0,
  // so the register can never settle on a non-BCD value.
  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (count_q[i*4 +: 4] >= DIG_MAX[i]) begin
          count_inc[i*4 +: 4] = 4'd0;
        end else begin
          count_inc[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Live count and overflow pulse; carry out of the top digit marks the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (clear_evt || state_q == ST_IDLE) begin
        count_q <= '0;
      end else if (tick) begin
        count_q    <= count_inc;
        overflow_q <= carry;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  // ---------------------------------------------------------------------------
  // Lap capture: freeze the display while the live count keeps running.
  // ---------------------------------------------------------------------------
  logic [23:0] lap_q;
  logic        lap_hold_q;
  logic        lap_evt;

  assign lap_evt = press[KEY_LAP];

  // Lap register and hold flag; lap presses in IDLE are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q      <= '0;
      lap_hold_q <= 1'b0;
    end else if (clear_evt) begin
      lap_q      <= '0;
      lap_hold_q <= 1'b0;
    end else if (lap_evt) begin
      if (state_q == ST_RUN) begin
        if (lap_hold_q) begin
          lap_hold_q <= 1'b0;
        end else begin
          lap_q      <= count_q;
          lap_hold_q <= 1'b1;
        end
      end else if (state_q == ST_PAUSE) begin
        lap_hold_q <= 1'b0;
      end
    end
  end

  assign sw.digits = lap_hold_q ? lap_q : count_q;
`else
  assign sw.digits = count_q;
`endif

  assign sw.running  = running_q;
  assign sw.overflow = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed bench for bcd_stopwatch with a 10-cycle tick and
// 4-cycle debounce. Inputs are driven and outputs sampled on the falling edge.
`timescale 1ns/1ps

module tb_bcd_stopwatch;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  bcd_stopwatch_if sw_if ();

  bcd_stopwatch #(
    .CLK_FREQ    (1000),
    .TICK_HZ     (100),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for running to reach a level; n = falling edges consumed.
  task automatic wait_run(input logic want, input int budget, output int n);
    n = 0;
    while (sw_if.running !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Bounded wait for a given digits value; n = falling edges consumed.
  task automatic wait_dig(input logic [23:0] want, input int budget, output int n);
    n = 0;
    while (sw_if.digits !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, n2;
    int          rise_at;
    logic [23:0] bad_val;
    logic        seen_ovf;

    rst_n             = 1'b0;
    sw_if.key_start_n = 1'b1;
    sw_if.key_clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
    sw_if.key_lap_n   = 1'b1;
`endif
    cycles(3);
    check("rst_digits",   32'(sw_if.digits),   32'h0);
    check("rst_running",  32'(sw_if.running),  32'h0);
    check("rst_overflow", 32'(sw_if.overflow), 32'h0);
    rst_n = 1'b1;
    cycles(5);
    check("idle_digits", 32'(sw_if.digits), 32'h0);

    // Bouncing start key: toggles every 2 cycles, never stable long enough.
    for (int i = 0; i < 15; i++) begin
      sw_if.key_start_n = ~sw_if.key_start_n;
      cycles(2);
    end
    sw_if.key_start_n = 1'b1;
    cycles(20);
    check("bounce_running", 32'(sw_if.running), 32'h0);
    check("bounce_digits",  32'(sw_if.digits),  32'h0);

    // Start held 10 cycles; running within 7, count 0x10 after 100 more cycles.
    rise_at = 0;
    sw_if.key_start_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rise_at == 0 && sw_if.running === 1'b1) rise_at = i;
    end
    sw_if.key_start_n = 1'b1;
    check("start_running", 32'(sw_if.running), 32'h1);
    check("start_latency", 32'(rise_at >= 1 && rise_at <= 7), 32'h1);
    cycles(rise_at + 99 - 10);
    check("first_100_minus1", 32'(sw_if.digits), 32'h000009);
    cycles(1);
    check("first_100", 32'(sw_if.digits), 32'h000010);

    // Pause at 0x37, stays frozen 200 cycles, resume increments within 10.
    wait_dig(24'h000037, 400, n);
    check("reach_37", 32'(sw_if.digits), 32'h000037);
    sw_if.key_start_n = 1'b0;
    wait_run(1'b0, 8, n);
    check("pause_running", 32'(sw_if.running), 32'h0);
    bad_val = 24'h000037;
    for (int i = 0; i < 200; i++) begin
      if (i == 4) sw_if.key_start_n = 1'b1;
      @(negedge clk);
      if (sw_if.digits !== 24'h000037) bad_val = sw_if.digits;
    end
    check("pause_hold", 32'(bad_val), 32'h000037);
    sw_if.key_start_n = 1'b0;
    wait_run(1'b1, 8, n);
    check("resume_running", 32'(sw_if.running), 32'h1);
    sw_if.key_start_n = 1'b1;
    wait_dig(24'h000038, 12, n);
    check("resume_digits", 32'(sw_if.digits), 32'h000038);
    check("resume_latency", 32'(n <= 10), 32'h1);

    // Wrap: pause, preload 59:59.99, resume and catch the overflow pulse.
    sw_if.key_start_n = 1'b0;
    wait_run(1'b0, 8, n);
    sw_if.key_start_n = 1'b1;
    check("pause2_running", 32'(sw_if.running), 32'h0);
    cycles(10);
    force dut.count_q = 24'h595999;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    check("preload", 32'(sw_if.digits), 32'h595999);
    check("preload_no_ovf", 32'(sw_if.overflow), 32'h0);
    sw_if.key_start_n = 1'b0;
    wait_run(1'b1, 8, n);
    sw_if.key_start_n = 1'b1;
    seen_ovf = 1'b0;
    for (int i = 0; i < 15 && !seen_ovf; i++) begin
      @(negedge clk);
      if (sw_if.overflow === 1'b1) seen_ovf = 1'b1;
    end
    check("wrap_overflow", 32'(seen_ovf), 32'h1);
    check("wrap_digits",   32'(sw_if.digits),  32'h000000);
    check("wrap_running",  32'(sw_if.running), 32'h1);
    @(negedge clk);
    check("wrap_pulse_len", 32'(sw_if.overflow), 32'h0);
    check("wrap_still_run", 32'(sw_if.running),  32'h1);

    // Start and clear pressed together in RUN at 0x000512: clear wins.
    wait_dig(24'h000512, 6000, n);
    check("reach_512", 32'(sw_if.digits), 32'h000512);
    sw_if.key_start_n = 1'b0;
    sw_if.key_clear_n = 1'b0;
    wait_run(1'b0, 8, n);
    sw_if.key_start_n = 1'b1;
    sw_if.key_clear_n = 1'b1;
    check("clr_start_running", 32'(sw_if.running), 32'h0);
    check("clr_start_digits",  32'(sw_if.digits),  32'h0);
    cycles(30);
    check("clr_idle_digits",  32'(sw_if.digits),  32'h0);
    check("clr_idle_running", 32'(sw_if.running), 32'h0);

    // Fresh start from IDLE: first tick exactly 10 cycles after entering RUN.
    sw_if.key_start_n = 1'b0;
    wait_run(1'b1, 8, n);
    sw_if.key_start_n = 1'b1;
    check("restart_running", 32'(sw_if.running), 32'h1);
    wait_dig(24'h000001, 12, n2);
    check("first_tick_digits", 32'(sw_if.digits), 32'h000001);
    check("first_tick_cycles", 32'(n2), 32'd10);

    // Asynchronous reset pulse between edges at 01:02.03.
    wait_dig(24'h010203, 63000, n);
    check("reach_010203", 32'(sw_if.digits), 32'h010203);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #0.5;
    check("async_rst_digits",  32'(sw_if.digits),  32'h0);
    check("async_rst_running", 32'(sw_if.running), 32'h0);
    #0.5;
    rst_n = 1'b1;
    cycles(50);
    check("post_rst_digits",  32'(sw_if.digits),  32'h0);
    check("post_rst_running", 32'(sw_if.running), 32'h0);
    sw_if.key_start_n = 1'b0;
    wait_run(1'b1, 8, n);
    sw_if.key_start_n = 1'b1;
    check("post_rst_start", 32'(sw_if.running), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
Stopwatch core producing six BCD digits (MM:SS.cc) for the seven-segment path: each digit feeds one decoder, and the decoded digits feed the scan stage. It sits directly upstream of the decoders and replaces the free-running seconds timer. It contains:
- Debouncing for two active-low push buttons.
- A run/pause/clear state machine.
- A centisecond tick divider.
- A cascaded BCD counter that wraps at 59:59.99.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
TICK_HZ, 100, count rate in Hz; divider terminal count = CLK_FREQ/TICK_HZ - 1
DEBOUNCE_CYC, 1000000, cycles a synchronised key level must stay stable before it is accepted (20 ms at 50 MHz)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
key_start_n  input  1  start/pause button, active-low, asynchronous to clk
key_clear_n  input  1  clear button, active-low, asynchronous to clk
digits  output  24  six BCD digits, [3:0]=centisec units, [7:4]=centisec tens, [11:8]=sec units, [15:12]=sec tens, [19:16]=min units, [23:20]=min tens
running  output  1  high while the FSM is in RUN
overflow  output  1  one-cycle pulse on wrap from 59:59.99 to 00:00.00

Behaviour:
- Reset (rst_n low, asynchronous):
  - digits = 0, running = 0, overflow = 0.
  - FSM goes to IDLE; divider count = 0.
  - Debounced key levels = 1 (released); synchronisers = 1.
- Key path, per key:
  - 2-FF synchroniser.
  - Stability counter: reloads on any change of the synchronised level; after DEBOUNCE_CYC stable cycles, the debounced level takes the synchronised value.
  - A press event is a one-cycle pulse on the debounced 1->0 transition. Release generates nothing.
  - Latency from a stable pin low to the press pulse is 2 + DEBOUNCE_CYC cycles, ±1.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: digits held at 0. start press -> RUN.
  - RUN: the divider counts. start press -> PAUSE.
  - PAUSE: divider and digits frozen; divider phase retained. start press -> RUN.
  - clear press in any state -> IDLE, digits = 0, divider = 0.
  - clear and start press in the same cycle: clear wins, next state IDLE.
- running is a registered decode of state == RUN and updates on the same edge as the state.
- Divider, only in RUN:
  - Counts 0..CLK_FREQ/TICK_HZ-1.
  - The tick is asserted in the cycle the count equals the terminal value; the count then returns to 0.
  - Entering RUN from IDLE starts from 0, so the first tick arrives CLK_FREQ/TICK_HZ cycles after the transition.
- BCD cascade, advanced on tick only:
  - Digit limits: d0 0-9, d1 0-9, d2 0-9, d3 0-5, d4 0-9, d5 0-5.
  - A digit increments when all lower digits are at their maximum; a digit at its maximum rolls to 0 with carry.
  - At 59:59.99, the next tick sets all digits to 0 and pulses overflow for exactly that one cycle. The FSM stays in RUN.
- digits is registered; it changes on the edge that consumes a tick.
- No digit ever holds a non-BCD value. d3 and d5 never exceed 5.
- Reset asserted mid-count clears everything immediately, without waiting for a clock edge.

Optional Feature:
Macro STOPWATCH_LAP_EN.
- Defined:
  - Adds input key_lap_n (1 bit, active-low), with the same synchroniser and debounce as the other keys.
  - Adds a 24-bit lap register; digits shows the lap register while lap_hold = 1, otherwise the live count.
  - A lap press in RUN copies the live count into the lap register and sets lap_hold = 1; counting continues underneath.
  - A second lap press in RUN, or a lap press in PAUSE, clears lap_hold.
  - clear or reset clears both lap_hold and the lap register.
  - A lap press in IDLE is ignored.
- Undefined: no key_lap_n port, no lap register; digits always shows the live count.

Test Plan:
All scenarios use CLK_FREQ=1000, TICK_HZ=100 (tick every 10 cycles), DEBOUNCE_CYC=4.
1. Reset, then start pressed and held 10 cycles -> running=1 within 7 cycles of the press; after 100 further cycles digits=24'h000010.
2. Start pressed while in RUN at digits=24'h000037 -> running=0; digits stays 24'h000037 for 200 cycles. A second press resumes, and the next increment comes no later than 10 cycles after resuming.
3. Preload the count to 24'h595999 via a RUN sequence (or a force in sim), then one tick -> digits=24'h000000, overflow high for exactly 1 cycle, running stays 1.
4. key_start_n toggling every 2 cycles for 30 cycles, then released -> no press event; state unchanged from IDLE.
5. start and clear debounced presses in the same cycle while in RUN at 24'h000512 -> IDLE, digits=0, running=0.
6. rst_n pulsed low for 1 ns between clock edges during RUN at 24'h010203 -> digits=0 and running=0 immediately. After release, the block stays IDLE until the next start press.
